// File: rtl/memory_pkg.sv
// memory_pkg
//   Shared types and helpers for the memory write controller.
//   - wc_state_t    : write-controller FSM states
//   - store_entry_t : one store-buffer entry at the default geometry
//   - strb_to_mask  : expands byte strobes into a per-bit mask
//   Package types cannot follow module parameters, so the mask helper works
//   at a fixed maximum width and callers truncate to their own word width.
package memory_pkg;

    localparam int unsigned DEF_MEMDATAWIDTH = 32;
    localparam int unsigned DEF_MEMDEPTH     = 16;
    localparam int unsigned DEF_STBDEPTH     = 4;

    // Widest word the mask helper supports (512-bit words).
    localparam int unsigned MASK_MAX_BYTES = 64;
    localparam int unsigned MASK_MAX_BITS  = MASK_MAX_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR
    } wc_state_t;

    typedef struct packed {
        logic [$clog2(DEF_MEMDEPTH)-1:0] pos;
        logic [DEF_MEMDATAWIDTH-1:0]     data;
        logic [DEF_MEMDATAWIDTH/8-1:0]   strb;
    } store_entry_t;

    // Bit k of strb becomes bits [8k+7:8k] of the returned mask.
    function automatic logic [MASK_MAX_BITS-1:0] strb_to_mask(
        input logic [MASK_MAX_BYTES-1:0] strb
    );
        logic [MASK_MAX_BITS-1:0] mask;
        mask = '0;
        for (int unsigned k = 0; k < MASK_MAX_BYTES; k++) begin
            mask[k*8 +: 8] = {8{strb[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/memory_write_controller_if.sv
// memory_write_controller_if
//   Bundles the M-stage store handshake and the memory read/write ports of
//   the write controller.
//   - slave  : view used by memory_write_controller
//   - master : view used by the surrounding pipeline / memory (or a bench)
//   Signal names keep the original _i/_o suffixes relative to the controller.
interface memory_write_controller_if
    import memory_pkg::*;
#(
    parameter int unsigned MEMDATAWIDTH = DEF_MEMDATAWIDTH,
    parameter int unsigned MEMDEPTH     = DEF_MEMDEPTH
);
    localparam int unsigned AW = $clog2(MEMDEPTH);
    localparam int unsigned SW = MEMDATAWIDTH / 8;

    // M-stage store request side
    logic                    m_write_en_i;
    logic [AW-1:0]           m_write_pos_i;
    logic [MEMDATAWIDTH-1:0] m_write_data_i;
    logic [SW-1:0]           m_write_strb_i;
    logic                    m_write_ready_o;
    logic                    m_write_done_o;
    logic                    busy_o;

    // Memory RMW read port
    logic                    mem_read_en_o;
    logic [AW-1:0]           mem_read_pos_o;
    logic [MEMDATAWIDTH-1:0] mem_read_data_i;
    logic                    mem_read_valid_i;

    // Memory write port
    logic                    mem_write_en_o;
    logic [AW-1:0]           mem_write_pos_o;
    logic [MEMDATAWIDTH-1:0] mem_write_data_o;

    modport slave (
        input  m_write_en_i, m_write_pos_i, m_write_data_i, m_write_strb_i,
        output m_write_ready_o, m_write_done_o, busy_o,
        output mem_read_en_o, mem_read_pos_o,
        input  mem_read_data_i, mem_read_valid_i,
        output mem_write_en_o, mem_write_pos_o, mem_write_data_o
    );

    modport master (
        output m_write_en_i, m_write_pos_i, m_write_data_i, m_write_strb_i,
        input  m_write_ready_o, m_write_done_o, busy_o,
        input  mem_read_en_o, mem_read_pos_o,
        output mem_read_data_i, mem_read_valid_i,
        input  mem_write_en_o, mem_write_pos_o, mem_write_data_o
    );

endinterface

// File: rtl/store_buffer_fifo.sv
// store_buffer_fifo
//   In-order store buffer. Pointers carry one extra wrap bit so full and
//   empty are decoded from pointer state alone.
//   Ports:
//   - clk, rst_n : clock, asynchronous active-low reset (empties the buffer)
//   - push, wr_data : enqueue (ignored when full, even with a pop this cycle)
//   - pop        : dequeue head (ignored when empty)
//   - head       : oldest entry, valid while !empty
//   - full, empty: occupancy flags
module store_buffer_fifo #(
    parameter type         T        = logic [7:0],
    parameter int unsigned STBDEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int unsigned PW = $clog2(STBDEPTH);

    T             entries [STBDEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Payload storage needs no reset: it is only read behind !empty.
    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/memory_write_controller.sv
// memory_write_controller
//   Accepts stores from the M stage into an in-order store buffer and
//   retires them to a memory without byte enables. Full-strobe stores are
//   written directly; partial-strobe stores read the word, merge the strobed
//   bytes and write it back; zero-strobe stores retire with no access.
//   Ports:
//   - clk_i, rst_ni : clock, asynchronous active-low reset
//   - bus (slave)   : store handshake (en/pos/data/strb, ready, done, busy),
//                     RMW read port (en/pos out, data/valid in),
//                     write port (en/pos/data out)
//   The interface instance must use the same MEMDATAWIDTH/MEMDEPTH.
module memory_write_controller
    import memory_pkg::*;
#(
    parameter int unsigned MEMDATAWIDTH = DEF_MEMDATAWIDTH,
    parameter int unsigned MEMDEPTH     = DEF_MEMDEPTH,
    parameter int unsigned STBDEPTH     = DEF_STBDEPTH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    memory_write_controller_if.slave    bus
);
    localparam int unsigned AW = $clog2(MEMDEPTH);
    localparam int unsigned SW = MEMDATAWIDTH / 8;

    typedef struct packed {
        logic [AW-1:0]           pos;
        logic [MEMDATAWIDTH-1:0] data;
        logic [SW-1:0]           strb;
    } entry_t;

    entry_t    wr_entry;
    entry_t    head;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;

    wc_state_t state;
    wc_state_t next_state;

    logic      head_full_strb;
    logic      head_nop;
    logic [MEMDATAWIDTH-1:0] byte_mask;
    logic [MEMDATAWIDTH-1:0] merged;

    logic                    read_en_d;
    logic                    write_en_d;
    logic                    done_d;
    logic [MEMDATAWIDTH-1:0] write_data_d;

    logic                    read_en_q;
    logic [AW-1:0]           read_pos_q;
    logic                    write_en_q;
    logic [AW-1:0]           write_pos_q;
    logic [MEMDATAWIDTH-1:0] write_data_q;
    logic                    done_q;

    // ---------------------------------------------------------------- buffer
    assign push              = bus.m_write_en_i && !full;
    assign wr_entry.pos      = bus.m_write_pos_i;
    assign wr_entry.data     = bus.m_write_data_i;
    assign wr_entry.strb     = bus.m_write_strb_i;

    store_buffer_fifo #(
        .T        (entry_t),
        .STBDEPTH (STBDEPTH)
    ) u_stb (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    assign head_full_strb = &head.strb;
    assign head_nop       = !empty && (head.strb == '0);

    // Mask helper is built at a fixed maximum width; the casts pad the strobe
    // up and trim the mask back down to this word width.
    assign byte_mask = MEMDATAWIDTH'(strb_to_mask(MASK_MAX_BYTES'(head.strb)));
    assign merged    = (bus.mem_read_data_i & ~byte_mask) | (head.data & byte_mask);

    // ------------------------------------------------------ state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= next_state;
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!empty && !head_nop) begin
                    next_state = head_full_strb ? WR : RD_REQ;
                end
            end
            RD_REQ:  next_state = RD_WAIT;
            RD_WAIT: if (bus.mem_read_valid_i) next_state = WR;
            WR:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Output flops load from next_state so each enable is high exactly while
    // the FSM sits in the matching state. The head is stable from IDLE until
    // the WR pop, so head.pos is a safe address source here.
    always_comb begin
        read_en_d    = (next_state == RD_REQ);
        write_en_d   = (next_state == WR);
        done_d       = (next_state == WR) || ((state == IDLE) && head_nop);
        pop          = (state == WR) || ((state == IDLE) && head_nop);
        write_data_d = (state == RD_WAIT) ? merged : head.data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_en_q    <= 1'b0;
            read_pos_q   <= '0;
            write_en_q   <= 1'b0;
            write_pos_q  <= '0;
            write_data_q <= '0;
            done_q       <= 1'b0;
        end else begin
            read_en_q  <= read_en_d;
            write_en_q <= write_en_d;
            done_q     <= done_d;
            if (read_en_d) read_pos_q <= head.pos;
            if (write_en_d) begin
                write_pos_q  <= head.pos;
                write_data_q <= write_data_d;
            end
        end
    end

    assign bus.m_write_ready_o  = !full;
    assign bus.busy_o           = !empty || (state != IDLE);
    assign bus.m_write_done_o   = done_q;
    assign bus.mem_read_en_o    = read_en_q;
    assign bus.mem_read_pos_o   = read_pos_q;
    assign bus.mem_write_en_o   = write_en_q;
    assign bus.mem_write_pos_o  = write_pos_q;
    assign bus.mem_write_data_o = write_data_q;

endmodule

// File: tb/tb_memory_write_controller.sv
// tb_memory_write_controller
//   Directed stores with hand-computed results. Stimulus pushes the expected
//   memory reads/writes into queues; a negedge monitor, which also models a
//   memory with a fixed read latency, pops and compares on every access.
module tb_memory_write_controller;

    localparam int RD_LAT = 2;

    typedef struct {
        logic [3:0]  pos;
        logic [31:0] data;
        int          due;   // expected cycle, -1 = not checked
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   done_cnt;
    int   rd_cnt;

    logic [31:0] mem_model [16];
    exp_t exp_wr[$];
    exp_t exp_rd[$];
    exp_t rd_pend[$];
    exp_t mon_e;

    memory_write_controller_if #(.MEMDATAWIDTH(32), .MEMDEPTH(16)) bus ();

    memory_write_controller #(
        .MEMDATAWIDTH (32),
        .MEMDEPTH     (16),
        .STBDEPTH     (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------ memory model + monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_pend.delete();
            bus.mem_read_valid_i = 1'b0;
            bus.mem_read_data_i  = '0;
        end else begin
            bus.mem_read_valid_i = 1'b0;
            if (rd_pend.size() > 0 && rd_pend[0].due == cyc) begin
                bus.mem_read_valid_i = 1'b1;
                bus.mem_read_data_i  = mem_model[rd_pend[0].pos];
                void'(rd_pend.pop_front());
            end
            if (bus.mem_read_en_o) begin
                rd_cnt++;
                if (exp_rd.size() == 0) begin
                    check("unexpected_read", 32'(bus.mem_read_pos_o), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_rd.pop_front();
                    check("read_pos", 32'(bus.mem_read_pos_o), 32'(mon_e.pos));
                    if (mon_e.due >= 0) check("read_cycle", 32'(cyc), 32'(mon_e.due));
                end
                rd_pend.push_back('{pos: bus.mem_read_pos_o, data: 32'h0, due: cyc + RD_LAT});
            end
            if (bus.m_write_done_o) done_cnt++;
            if (bus.mem_write_en_o) begin
                check("done_with_write", 32'(bus.m_write_done_o), 32'd1);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(bus.mem_write_pos_o), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("write_pos", 32'(bus.mem_write_pos_o), 32'(mon_e.pos));
                    check("write_data", bus.mem_write_data_o, mon_e.data);
                    if (mon_e.due >= 0) check("write_cycle", 32'(cyc), 32'(mon_e.due));
                end
                mem_model[bus.mem_write_pos_o] = bus.mem_write_data_o;
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    // Drives one store for one cycle (called just after a posedge); returns
    // the cycle in which it was offered.
    task automatic offer(input logic [3:0] pos, input logic [31:0] data,
                         input logic [3:0] strb, input logic exp_ready,
                         output int acc_cyc);
        bus.m_write_en_i   = 1'b1;
        bus.m_write_pos_i  = pos;
        bus.m_write_data_i = data;
        bus.m_write_strb_i = strb;
        @(negedge clk);
        check("ready", 32'(bus.m_write_ready_o), 32'(exp_ready));
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.m_write_en_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy_o || exp_wr.size() != 0) && n < max_cyc);
        check("idle_within_budget", 32'(n < max_cyc), 32'd1);
        repeat (2) @(negedge clk);
        check("busy_after_drain", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int d0;
        int r0;
        int n;

        rst_n = 1'b0;
        n_cmp = 0; n_err = 0; done_cnt = 0; rd_cnt = 0;
        bus.m_write_en_i   = 1'b0;
        bus.m_write_pos_i  = '0;
        bus.m_write_data_i = '0;
        bus.m_write_strb_i = '0;
        for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;
        mem_model[2] = 32'h1122_3344;
        mem_model[4] = 32'hCAFE_F00D;
        mem_model[5] = 32'h0BAD_C0DE;
        mem_model[6] = 32'hFFFF_FFFF;
        mem_model[7] = 32'h1234_5678;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.m_write_ready_o), 32'd1);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.m_write_done_o), 32'd0);
        check("rst_write_pos", 32'(bus.mem_write_pos_o), 32'd0);
        check("rst_write_data", bus.mem_write_data_o, 32'd0);
        check("rst_read_pos", 32'(bus.mem_read_pos_o), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.m_write_ready_o), 32'd1);
            check("idle_busy", 32'(bus.busy_o), 32'd0);
            check("idle_read_en", 32'(bus.mem_read_en_o), 32'd0);
            check("idle_write_en", 32'(bus.mem_write_en_o), 32'd0);
        end
        @(posedge clk);
        #1;

        // Full-strobe store: direct write two cycles after acceptance
        d0 = done_cnt;
        offer(4'd1, 32'hDEAD_BEEF, 4'hF, 1'b1, acc);
        exp_wr.push_back('{pos: 4'd1, data: 32'hDEAD_BEEF, due: acc + 2});
        wait_idle(50);
        check("full_done_count", 32'(done_cnt - d0), 32'd1);

        // Partial store: RMW over 11223344
        d0 = done_cnt;
        offer(4'd2, 32'h0000_00AA, 4'h1, 1'b1, acc);
        exp_rd.push_back('{pos: 4'd2, data: 32'h0, due: acc + 2});
        exp_wr.push_back('{pos: 4'd2, data: 32'h1122_33AA, due: acc + 3 + RD_LAT});
        wait_idle(50);
        check("partial_done_count", 32'(done_cnt - d0), 32'd1);

        // Fill the buffer with four slow RMW stores; the fifth must be refused
        d0 = done_cnt;
        offer(4'd4, 32'h0000_1234, 4'h3, 1'b1, acc);
        exp_rd.push_back('{pos: 4'd4, data: 32'h0, due: -1});
        exp_wr.push_back('{pos: 4'd4, data: 32'hCAFE_1234, due: -1});
        offer(4'd5, 32'h5678_0000, 4'hC, 1'b1, acc);
        exp_rd.push_back('{pos: 4'd5, data: 32'h0, due: -1});
        exp_wr.push_back('{pos: 4'd5, data: 32'h5678_C0DE, due: -1});
        offer(4'd6, 32'h0000_9900, 4'h2, 1'b1, acc);
        exp_rd.push_back('{pos: 4'd6, data: 32'h0, due: -1});
        exp_wr.push_back('{pos: 4'd6, data: 32'hFFFF_99FF, due: -1});
        offer(4'd7, 32'h00AB_CD00, 4'h6, 1'b1, acc);
        exp_rd.push_back('{pos: 4'd7, data: 32'h0, due: -1});
        exp_wr.push_back('{pos: 4'd7, data: 32'h12AB_CD78, due: -1});
        offer(4'd8, 32'hDEAD_DEAD, 4'hF, 1'b0, acc);
        check("busy_while_full", 32'(bus.busy_o), 32'd1);
        wait_idle(200);
        check("fill_done_count", 32'(done_cnt - d0), 32'd4);

        // Two RMWs to the same word: the second must see the first's write
        d0 = done_cnt;
        offer(4'd3, 32'h0000_0055, 4'h1, 1'b1, acc);
        exp_rd.push_back('{pos: 4'd3, data: 32'h0, due: -1});
        exp_wr.push_back('{pos: 4'd3, data: 32'h0000_0055, due: -1});
        offer(4'd3, 32'h6600_0000, 4'h8, 1'b1, acc);
        exp_rd.push_back('{pos: 4'd3, data: 32'h0, due: -1});
        exp_wr.push_back('{pos: 4'd3, data: 32'h6600_0055, due: -1});
        wait_idle(100);
        check("same_word_final", mem_model[3], 32'h6600_0055);
        check("same_word_done_count", 32'(done_cnt - d0), 32'd2);

        // Zero-strobe store: retires with no memory access
        d0 = done_cnt;
        offer(4'd9, 32'h1234_5678, 4'h0, 1'b1, acc);
        wait_idle(50);
        check("nop_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset while waiting for RMW read data, with a second store queued
        r0 = rd_cnt;
        exp_rd.push_back('{pos: 4'd10, data: 32'h0, due: -1});
        offer(4'd10, 32'h0000_0077, 4'h1, 1'b1, acc);
        offer(4'd11, 32'h0000_0088, 4'h1, 1'b1, acc);
        n = 0;
        while (rd_cnt == r0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("read_before_reset", 32'(rd_cnt - r0), 32'd1);
        @(posedge clk);
        #2;
        check("busy_before_reset", 32'(bus.busy_o), 32'd1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_read_en", 32'(bus.mem_read_en_o), 32'd0);
        check("mid_rst_write_en", 32'(bus.mem_write_en_o), 32'd0);
        check("mid_rst_done", 32'(bus.m_write_done_o), 32'd0);
        check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        check("mid_rst_ready", 32'(bus.m_write_ready_o), 32'd1);
        check("mid_rst_read_pos", 32'(bus.mem_read_pos_o), 32'd0);
        check("mid_rst_write_pos", 32'(bus.mem_write_pos_o), 32'd0);
        check("mid_rst_write_data", bus.mem_write_data_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", 32'(bus.busy_o), 32'd0);
        check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("post_rst_mem10", mem_model[10], 32'h0);

        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("pending_reads", 32'(exp_rd.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_cmp++;
        n_err++;
        $display("FAIL global_timeout: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
